clock_step_control: RTL and testbench

CLOCK_STEP_CONTROL -- requirements
Module: clock_step_control

---
 rtl/clock_step_control.sv | 160 ++++++++++++++++
 tb/tb_clock_step_control.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_step_control.sv
`default_nettype none
// ============================================================================
// Module      : clock_step_control
// Description : SAP1 clock-enable generator. Produces mclk_en in free-run mode
//               (divided from mclk), in single-step mode (one pulse per
//               debounced button press) and holds it low forever once the CPU
//               raises HLT.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_step_control #(
    parameter int DIV_WIDTH       = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 mclk,
    input  logic                 mrst_n,
    input  logic                 run_mode,
    input  logic                 step_btn,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 halt,
    output logic                 mclk_en,
    output logic                 halted,
    output logic                 stepping
);

    // Debounce counter is wide enough for the largest legal DEBOUNCE_CYCLES.
    localparam int                c_DB_W     = 16;
    localparam logic [c_DB_W-1:0] c_DB_LIMIT = c_DB_W'(DEBOUNCE_CYCLES);
    localparam logic [c_DB_W-1:0] c_DB_ONE   = c_DB_W'(1);
    localparam logic [DIV_WIDTH-1:0] c_PRESC_ONE  = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] c_PRESC_ZERO = '0;

    // FSM encoding
    localparam logic [1:0] c_ST_STEP = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_HALT = 2'd2;

    // Synchronizer stages
    logic r_run_meta;
    logic r_run_sync;
    logic r_btn_meta;
    logic r_btn_sync;

    // Debouncer state
    logic [c_DB_W-1:0] r_db_cnt;
    logic              r_db_level;
    logic              r_db_prev;

    // FSM, prescaler and registered outputs
    logic [1:0]           r_state;
    logic [DIV_WIDTH-1:0] r_presc;
    logic                 r_mclk_en;
    logic                 r_halted;
    logic                 r_stepping;

    // Combinational helpers
    logic                 w_step_req;
    logic [1:0]           w_state_nxt;
    logic                 w_presc_hit;
    logic [DIV_WIDTH-1:0] w_presc_inc;

    // Two-flop synchronizers for the asynchronous mode switch and button.
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            r_run_meta <= 1'b0;
            r_run_sync <= 1'b0;
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
        end else begin
            r_run_meta <= run_mode;
            r_run_sync <= r_run_meta;
            r_btn_meta <= step_btn;
            r_btn_sync <= r_btn_meta;
        end
    end

    // Debouncer: the level follows the button only after it has disagreed
    // with the current level for DEBOUNCE_CYCLES consecutive cycles; any
    // agreement in between restarts the count.
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            r_db_cnt   <= '0;
            r_db_level <= 1'b0;
            r_db_prev  <= 1'b0;
        end else begin
            r_db_prev <= r_db_level;
            if (r_btn_sync == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_LIMIT) begin
                r_db_level <= r_btn_sync;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + c_DB_ONE;
            end
        end
    end

    // One-cycle step request on the rising edge of the debounced level.
    assign w_step_req = r_db_level & ~r_db_prev;

    // Prescaler compare against the live divisor, so a new div applies at
    // the very next comparison. A prescaler already past the new div simply
    // keeps counting through its natural 2^DIV_WIDTH wrap.
    assign w_presc_hit = (r_presc == div);
    assign w_presc_inc = r_presc + c_PRESC_ONE;

    // Next-state logic: HALT is sticky and halt overrides any mode change.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == c_ST_HALT) begin
            w_state_nxt = c_ST_HALT;
        end else if (halt) begin
            w_state_nxt = c_ST_HALT;
        end else begin
            case (r_state)
                c_ST_STEP: w_state_nxt = r_run_sync ? c_ST_RUN  : c_ST_STEP;
                c_ST_RUN:  w_state_nxt = r_run_sync ? c_ST_RUN  : c_ST_STEP;
                default:   w_state_nxt = c_ST_STEP;
            endcase
        end
    end

    // FSM state, prescaler and the registered outputs. Enables are only
    // issued when the machine stays in the same state across the edge, which
    // drops step requests that collide with a mode change and suppresses
    // every pulse when halt arrives.
    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            r_state    <= c_ST_STEP;
            r_presc    <= '0;
            r_mclk_en  <= 1'b0;
            r_halted   <= 1'b0;
            r_stepping <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_halted   <= (w_state_nxt == c_ST_HALT);
            r_stepping <= (w_state_nxt == c_ST_STEP);

            if ((w_state_nxt == c_ST_RUN) && (r_state == c_ST_RUN)) begin
                r_presc <= w_presc_hit ? c_PRESC_ZERO : w_presc_inc;
            end else begin
                // Cleared on RUN entry, parked at zero elsewhere.
                r_presc <= '0;
            end

            if ((w_state_nxt == c_ST_RUN) && (r_state == c_ST_RUN)) begin
                r_mclk_en <= w_presc_hit;
            end else if ((w_state_nxt == c_ST_STEP) && (r_state == c_ST_STEP)) begin
                r_mclk_en <= w_step_req;
            end else begin
                r_mclk_en <= 1'b0;
            end
        end
    end

    assign mclk_en  = r_mclk_en;
    assign halted   = r_halted;
    assign stepping = r_stepping;

endmodule
`default_nettype wire

// File: tb/tb_clock_step_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_step_control
// Description : Directed self-checking bench for clock_step_control with
//               DEBOUNCE_CYCLES=4 and DIV_WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_step_control;

    localparam int DIV_WIDTH = 8;
    localparam int DEB       = 4;

    logic                 mclk     = 1'b0;
    logic                 mrst_n   = 1'b0;
    logic                 run_mode = 1'b0;
    logic                 step_btn = 1'b0;
    logic                 halt     = 1'b0;
    logic [DIV_WIDTH-1:0] div      = '0;
    logic                 mclk_en;
    logic                 halted;
    logic                 stepping;

    int n_err    = 0;
    int n_checks = 0;
    int c, f, c2, f2, cb, last, bad, tot;

    clock_step_control #(
        .DIV_WIDTH       (DIV_WIDTH),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .mclk     (mclk),
        .mrst_n   (mrst_n),
        .run_mode (run_mode),
        .step_btn (step_btn),
        .div      (div),
        .halt     (halt),
        .mclk_en  (mclk_en),
        .halted   (halted),
        .stepping (stepping)
    );

    // Posedges at 5,15,25...; sampling and driving happen on negedges.
    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Sample mclk_en on the next n negedges; index k is the negedge that
    // follows the k-th posedge after the call.
    task automatic count_pulses(input int n, output int cnt, output int first);
        cnt   = 0;
        first = -1;
        for (int k = 0; k < n; k++) begin
            @(negedge mclk);
            if (mclk_en === 1'b1) begin
                if (first < 0) first = k;
                cnt++;
            end
        end
    endtask

    initial begin
        // ---------------- reset ----------------
        repeat (3) @(negedge mclk);
        chk("rst_mclk_en", mclk_en, 0);
        chk("rst_halted", halted, 0);
        chk("rst_stepping", stepping, 1);
        mrst_n = 1'b1;
        repeat (3) @(negedge mclk);
        chk("idle_mclk_en", mclk_en, 0);
        chk("idle_stepping", stepping, 1);

        // ---------------- single step, clean press held 50 cycles ----------
        step_btn = 1'b1;
        count_pulses(50, c, f);
        chk("step_first", f, 7);
        chk("step_count", c, 1);
        step_btn = 1'b0;
        count_pulses(15, c2, f2);
        chk("step_release", c2, 0);

        // ---------------- bounce ----------------
        cb = 0;
        for (int i = 0; i < 20; i++) begin
            step_btn = (((i / 2) % 2) == 0);
            @(negedge mclk);
            if (mclk_en === 1'b1) cb++;
        end
        chk("bounce_none", cb, 0);
        step_btn = 1'b1;
        count_pulses(30, c, f);
        chk("bounce_count", c, 1);
        chk("bounce_first", f, 7);
        step_btn = 1'b0;
        repeat (15) @(negedge mclk);

        // ---------------- free run, div=3 ----------------
        div      = 8'd3;
        run_mode = 1'b1;
        c = 0; f = -1; last = -1; bad = 0;
        for (int k = 0; k < 106; k++) begin
            @(negedge mclk);
            if (k == 2) chk("run_stepping", stepping, 0);
            if (mclk_en === 1'b1) begin
                if (f < 0) f = k;
                else if (k - last != 4) bad++;
                last = k;
                c++;
            end
        end
        chk("run_first", f, 6);
        chk("run_count", c, 25);
        chk("run_gap", bad, 0);
        chk("run_halted", halted, 0);

        // ---------------- div lowered below prescaler ----------------
        // Prescaler is 3 here; it must run through 255 -> 0 before hitting 1.
        div = 8'd1;
        count_pulses(260, c, f);
        chk("divchg_first", f, 254);
        chk("divchg_count", c, 3);

        // ---------------- back to step mode ----------------
        run_mode = 1'b0;
        repeat (6) @(negedge mclk);
        chk("back_stepping", stepping, 1);
        count_pulses(10, c, f);
        chk("back_quiet", c, 0);

        // ---------------- mode race ----------------
        // Step request lands in the same cycle synchronized run_mode rises.
        div      = 8'd2;
        step_btn = 1'b1;
        c = 0; f = -1;
        for (int k = 0; k < 13; k++) begin
            @(negedge mclk);
            if (mclk_en === 1'b1) begin
                if (f < 0) f = k;
                c++;
            end
            if (k == 4) run_mode = 1'b1;
        end
        chk("race_first", f, 10);
        chk("race_count", c, 1);
        chk("race_stepping", stepping, 0);

        // ---------------- halt ----------------
        step_btn = 1'b0;
        run_mode = 1'b0;
        repeat (10) @(negedge mclk);
        div      = 8'd0;
        run_mode = 1'b1;
        repeat (10) @(negedge mclk);
        count_pulses(5, c, f);
        chk("div0_every", c, 5);
        halt = 1'b1;
        @(negedge mclk);
        halt = 1'b0;
        chk("halt_mclk_en", mclk_en, 0);
        chk("halt_halted", halted, 1);
        chk("halt_stepping", stepping, 0);
        tot = 0;
        run_mode = 1'b0;
        count_pulses(10, c, f);
        tot += c;
        step_btn = 1'b1;
        count_pulses(20, c, f);
        tot += c;
        step_btn = 1'b0;
        run_mode = 1'b1;
        count_pulses(10, c, f);
        tot += c;
        chk("halt_quiet", tot, 0);
        chk("halt_sticky", halted, 1);

        // ---------------- asynchronous reset from HALT ----------------
        @(negedge mclk);
        #2 mrst_n = 1'b0;
        #1;
        chk("arst_halted", halted, 0);
        chk("arst_stepping", stepping, 1);
        @(negedge mclk);
        mrst_n = 1'b1;
        repeat (10) @(negedge mclk);
        chk("rerun_mclk_en", mclk_en, 1);
        chk("rerun_stepping", stepping, 0);
        chk("rerun_halted", halted, 0);

        // ---------------- asynchronous reset mid-run ----------------
        #2 mrst_n = 1'b0;
        #1;
        chk("arst_run_mclk_en", mclk_en, 0);
        chk("arst_run_stepping", stepping, 1);
        repeat (2) @(negedge mclk);
        chk("arst_hold_mclk_en", mclk_en, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
